// File: rtl/mem_responder_pkg.sv
// Shared types and default sizing for the byte-wide memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_responder_pkg;

  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;
  localparam int BURST_LEN_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST_RD = 2'd1,
    BURST_WR = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder.sv
// Byte-addressed memory responder: single reads/writes plus BURST_LEN-beat vector bursts.
// Latency: read data registered, 1 cycle after the request edge; bursts stream one beat per cycle.
// Backpressure: none; Busy is high during a burst and any request then is dropped.
//
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-low reset
//   MemRead, wren  - read / write request (both together = write-through)
//   VBurst         - turns the request into a BURST_LEN-beat transfer from address
//   address, data  - byte address (burst base) and write data (one beat per cycle)
//   q, qValid      - registered read data and its one-cycle valid
//   Busy           - burst in progress
//   Beat           - index of the beat on q, or of the beat just written
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              wren,
  input  logic              VBurst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  output logic              qValid,
  output logic              Busy,
  output logic [1:0]        Beat
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  // A one-beat burst completes on its accept edge, so it never leaves IDLE.
  localparam bit MULTI_BEAT = (BURST_LEN > 1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;   // index of the beat handled at the next edge
  logic [ADDR_W-1:0]   base;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   acc_addr;
  logic                wr_en;

  assign Busy = (state != IDLE);

  // Single port: in IDLE the request address is used, inside a burst the
  // running base+cnt address (wraps naturally at ADDR_W bits).
  always_comb begin
    acc_addr = address;
    if (state != IDLE) begin
      acc_addr = base + ADDR_W'(cnt);
    end
  end

  // Burst-write beats are written regardless of wren; reset blocks every write.
  always_comb begin
    wr_en = 1'b0;
    if (reset) begin
      wr_en = ((state == IDLE) && wren) || (state == BURST_WR);
    end
  end

  // Storage is never reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[acc_addr] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      q      <= '0;
      qValid <= 1'b0;
      Beat   <= 2'd0;
      cnt    <= '0;
      base   <= '0;
    end else begin
      case (state)
        IDLE: begin
          qValid <= 1'b0;
          if (wren) begin
            Beat <= 2'd0;
            if (VBurst) begin
              // A burst with MemRead also set is still a plain burst write.
              base  <= address;
              cnt   <= CNT_W'(1);
              state <= MULTI_BEAT ? BURST_WR : IDLE;
            end else if (MemRead) begin
              // Write-through: the memory read would return stale data, so
              // forward the incoming byte instead.
              q      <= data;
              qValid <= 1'b1;
            end
          end else if (MemRead) begin
            q      <= mem[address];
            qValid <= 1'b1;
            Beat   <= 2'd0;
            if (VBurst) begin
              base  <= address;
              cnt   <= CNT_W'(1);
              state <= MULTI_BEAT ? BURST_RD : IDLE;
            end
          end
        end

        BURST_RD: begin
          q      <= mem[acc_addr];
          qValid <= 1'b1;
          Beat   <= 2'(cnt);
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end

        BURST_WR: begin
          qValid <= 1'b0;
          Beat   <= 2'(cnt);
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BEAT) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against an array-based memory model.
// Latency: checks every output 1 ns after each rising edge.
// Backpressure: drives random noise requests during bursts; they must be dropped.
module tb_mem_responder;

  logic       clock;
  logic       reset;
  logic       MemRead;
  logic       wren;
  logic       VBurst;
  logic [7:0] address;
  logic [7:0] data;
  logic [7:0] q;
  logic       qValid;
  logic       Busy;
  logic [1:0] Beat;

  mem_responder dut (
    .clock   (clock),
    .reset   (reset),
    .MemRead (MemRead),
    .wren    (wren),
    .VBurst  (VBurst),
    .address (address),
    .data    (data),
    .q       (q),
    .qValid  (qValid),
    .Busy    (Busy),
    .Beat    (Beat)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: contents of every byte and the byte last presented on q.
  logic [7:0] mem_m [256];
  logic [7:0] q_m;
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic mr, input logic wr, input logic vb,
                       input logic [7:0] a, input logic [7:0] d);
    MemRead = mr;
    wren    = wr;
    VBurst  = vb;
    address = a;
    data    = d;
  endtask

  // Random requests presented while a burst is running; d is the beat data.
  task automatic noise(input logic [7:0] d);
    drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          8'($urandom), d);
  endtask

  function automatic logic [7:0] pick_addr();
    if ($urandom_range(0, 3) == 0) return 8'(8'hFC + $urandom_range(0, 3));
    return 8'($urandom);
  endfunction

  task automatic op_write(input logic [7:0] a, input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b0, a, d);
    tick();
    mem_m[a] = d;
    chk("wr_qvalid", qValid, 0);
    chk("wr_q_held", q, q_m);
    chk("wr_busy", Busy, 0);
    chk("wr_beat", Beat, 0);
  endtask

  task automatic op_read(input logic [7:0] a);
    drive(1'b1, 1'b0, 1'b0, a, 8'($urandom));
    tick();
    q_m = mem_m[a];
    chk("rd_q", q, q_m);
    chk("rd_qvalid", qValid, 1);
    chk("rd_beat", Beat, 0);
    chk("rd_busy", Busy, 0);
  endtask

  task automatic op_wthru(input logic [7:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, 1'b0, a, d);
    tick();
    mem_m[a] = d;
    q_m = d;
    chk("wt_q", q, q_m);
    chk("wt_qvalid", qValid, 1);
    chk("wt_busy", Busy, 0);
  endtask

  task automatic op_idle(input logic vb);
    drive(1'b0, 1'b0, vb, 8'($urandom), 8'($urandom));
    tick();
    chk("idle_qvalid", qValid, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_q_held", q, q_m);
  endtask

  task automatic op_bwrite(input logic [7:0] b, input logic both, input logic [31:0] d);
    drive(both, 1'b1, 1'b1, b, d[7:0]);
    tick();
    mem_m[b] = d[7:0];
    chk("bw0_busy", Busy, 1);
    chk("bw0_qvalid", qValid, 0);
    chk("bw0_beat", Beat, 0);
    chk("bw0_q_held", q, q_m);
    for (int i = 1; i < 4; i++) begin
      noise(d[8*i +: 8]);
      tick();
      mem_m[8'(b + i)] = d[8*i +: 8];
      chk("bw_beat", Beat, i);
      chk("bw_busy", Busy, (i < 3) ? 1 : 0);
      chk("bw_qvalid", qValid, 0);
    end
  endtask

  // hit30: noise is a single write to 0x30, which must be ignored.
  task automatic op_bread(input logic [7:0] b, input bit hit30);
    drive(1'b1, 1'b0, 1'b1, b, 8'($urandom));
    tick();
    q_m = mem_m[b];
    chk("br0_q", q, q_m);
    chk("br0_qvalid", qValid, 1);
    chk("br0_beat", Beat, 0);
    chk("br0_busy", Busy, 1);
    for (int i = 1; i < 4; i++) begin
      if (hit30) drive(1'b0, 1'b1, 1'b0, 8'h30, 8'hEE);
      else       noise(8'($urandom));
      tick();
      q_m = mem_m[8'(b + i)];
      chk("br_q", q, q_m);
      chk("br_qvalid", qValid, 1);
      chk("br_beat", Beat, i);
      chk("br_busy", Busy, (i < 3) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    tick();
    q_m = 8'h00;
    chk("rst_q", q, 0);
    chk("rst_qvalid", qValid, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_beat", Beat, 0);
    reset = 1'b1;

    // Give every byte a known value.
    for (int a = 0; a < 256; a++) op_write(8'(a), 8'($urandom));

    // Write then read back, valid for one cycle only.
    op_write(8'h10, 8'h5A);
    op_read(8'h10);
    chk("d22_q", q, 8'h5A);
    op_idle(1'b0);

    // Burst write then burst read at 0x20.
    op_bwrite(8'h20, 1'b0, 32'h44332211);
    op_bread(8'h20, 1'b0);
    chk("d23_last_q", q, 8'h44);

    // Wrapping burst at 0xFE, verified by single reads.
    op_bwrite(8'hFE, 1'b0, 32'hD4C3B2A1);
    op_read(8'hFE); chk("d24_fe", q, 8'hA1);
    op_read(8'hFF); chk("d24_ff", q, 8'hB2);
    op_read(8'h00); chk("d24_00", q, 8'hC3);
    op_read(8'h01); chk("d24_01", q, 8'hD4);

    // Writes to 0x30 during a burst read are dropped.
    op_write(8'h30, 8'h3C);
    op_bread(8'h20, 1'b1);
    op_read(8'h30);
    chk("d25_mem30", q, 8'h3C);

    // Reset after beat 1 of a burst write at 0x40.
    op_write(8'h42, 8'h0A);
    op_write(8'h43, 8'h0B);
    drive(1'b0, 1'b1, 1'b1, 8'h40, 8'h91);
    tick();
    mem_m[8'h40] = 8'h91;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h92);
    tick();
    mem_m[8'h41] = 8'h92;
    chk("d26_beat1", Beat, 1);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'h42, 8'h93);
    tick();
    q_m = 8'h00;
    chk("d26_q", q, 0);
    chk("d26_qvalid", qValid, 0);
    chk("d26_busy", Busy, 0);
    chk("d26_beat", Beat, 0);
    reset = 1'b1;
    op_idle(1'b0);
    op_read(8'h40); chk("d26_m40", q, 8'h91);
    op_read(8'h41); chk("d26_m41", q, 8'h92);
    op_read(8'h42); chk("d26_m42", q, 8'h0A);
    op_read(8'h43); chk("d26_m43", q, 8'h0B);

    // Write-through.
    op_wthru(8'h05, 8'h77);
    chk("d27_q", q, 8'h77);
    op_read(8'h05);

    // VBurst alone is not a request; burst with both strobes is a write.
    op_idle(1'b1);
    op_bwrite(8'h60, 1'b1, 32'h0D0C0B0A);
    op_bread(8'h60, 1'b0);

    // Random back-to-back traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 6))
        0: op_write(pick_addr(), 8'($urandom));
        1: op_read(pick_addr());
        2: op_wthru(pick_addr(), 8'($urandom));
        3: op_bwrite(pick_addr(), 1'($urandom_range(0, 1)), $urandom);
        4: op_bread(pick_addr(), 1'b0);
        5: op_idle(1'($urandom_range(0, 1)));
        default: op_read(pick_addr());
      endcase
    end

    // Full readback of the memory image.
    for (int a = 0; a < 256; a++) op_read(8'(a));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the address width and a storage depth of 2^ADDR_W bytes.
REQ-002 Parameter DATA_W, default 8, SHALL set the byte/data width.
REQ-003 Parameter BURST_LEN, default 4, SHALL set the beats per vector burst, one beat per 8-bit vector lane.
REQ-004 Port list:
  - clock  in  1  single clock; all state changes on its rising edge.
  - reset  in  1  synchronous active-low reset.
  - MemRead  in  1  single-byte read request.
  - wren  in  1  single-byte write request.
  - VBurst  in  1  qualifies MemRead or wren as a BURST_LEN-beat vector transfer.
  - address  in  ADDR_W  byte address; burst base address.
  - data  in  DATA_W  write data; one beat per cycle during a burst write.
  - q  out  DATA_W  registered read data.
  - qValid  out  1  q holds a new beat this cycle.
  - Busy  out  1  burst in progress; requests are ignored.
  - Beat  out  2  index of the beat currently on q, or of the beat just written.

Function
REQ-005 States SHALL be: IDLE, BURST_RD and BURST_WR; Busy = (state != IDLE), decoded combinationally.
REQ-006 A request SHALL be accepted only in IDLE; any request while Busy is ignored (no write, q/qValid unaffected by it).
REQ-007 Single read (IDLE, MemRead=1, wren=0, VBurst=0): the next edge SHALL load q with mem[address], set qValid=1 for exactly one cycle, and set Beat=0; latency is 1 cycle.
REQ-008 Single write (IDLE, wren=1, VBurst=0): the same edge SHALL write data to mem[address]; qValid=0 and q is held.
REQ-009 Simultaneous MemRead and wren in IDLE SHALL perform the write and return the written data on q with qValid=1 (write-through).
REQ-010 Burst read (IDLE, MemRead=1, VBurst=1): the accept edge E0 SHALL latch base=address, load q=mem[base], set Beat=0 and enter BURST_RD.
REQ-011 In BURST_RD, edges E1..E(BURST_LEN-1) SHALL load q=mem[base+i] with Beat=i; qValid SHALL stay 1 for BURST_LEN consecutive cycles; edge E(BURST_LEN-1) SHALL return the state to IDLE.
REQ-012 Burst write (IDLE, wren=1, VBurst=1): E0 SHALL write data to mem[base] and enter BURST_WR; edges E1..E(BURST_LEN-1) SHALL write the data sampled on that edge to mem[base+i]; the last edge SHALL return the state to IDLE.
REQ-013 A burst with MemRead=wren=1 SHALL be treated as a burst write.
REQ-014 Burst addresses SHALL wrap modulo 2^ADDR_W (base 0xFE -> 0xFE, 0xFF, 0x00, 0x01).
REQ-015 A new request SHALL be acceptable in the cycle immediately after the final burst edge (back-to-back, no dead cycle).
REQ-016 VBurst=1 with neither MemRead nor wren SHALL be ignored.

Reset
REQ-017 While reset=0 at an edge: state=IDLE, q=0, qValid=0, Beat=0, the burst counter and base SHALL be cleared, and no memory write SHALL occur.
REQ-018 Reset mid-burst SHALL abort the burst; beats already written remain; no further beats are written.
REQ-019 Storage contents SHALL NOT be cleared by reset.

Structure
REQ-020 Package mem_responder_pkg SHALL hold the state enumeration and the ADDR_W, DATA_W and BURST_LEN defaults.
REQ-021 The block SHALL be a single module with inferred single-port synchronous storage; no sub-module.

Verification
REQ-022 Write 0x5A to 0x10, then read 0x10 -> q=0x5A, qValid high for exactly one cycle, one cycle after the request.
REQ-023 Burst write 0x11, 0x22, 0x33, 0x44 at base 0x20, then burst read 0x20 -> q=0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, Beat=0..3, Busy high for 3 cycles.
REQ-024 Burst write at base 0xFE -> single reads of 0xFE, 0xFF, 0x00, 0x01 return beats 0..3 in order.
REQ-025 Assert wren to 0x30 while Busy during a burst read -> mem[0x30] is unchanged and the burst data is unaffected.
REQ-026 Assert reset=0 after beat 1 of a burst write at 0x40 -> 0x40 and 0x41 are written, 0x42 and 0x43 are unchanged, outputs are 0 and the state is IDLE.
REQ-027 MemRead=wren=1 with data 0x77 at address 0x05 -> mem[0x05]=0x77 and q=0x77 with qValid=1.
